role_dealer: RTL and testbench
==============================

Name: role_dealer

Overview:
- Sequential, parametrised successor to the fixed 5-player seed table.
- Deals a fresh role assignment for N_PLAYERS players with configurable wolf and doctor counts, driven by a seedable 16-bit Galois LFSR with optional entropy injection.
- Sits between the game-setup FSM, which pulses start, and the per-player role registers and display logic, which consume roles.

Parameters:
- N_PLAYERS, 5, player count; legal range 2..16.
- N_WOLVES, 1, wolves to deal; must be at least 1.
- N_DOCTORS, 1, doctors to deal; may be 0. Elaboration fails if N_WOLVES+N_DOCTORS > N_PLAYERS.
- LFSR_TAPS, 16'hB400, Galois feedback mask for the 16-bit LFSR.
- SEED_DEFAULT, 16'hACE1, reset value of the LFSR; also replaces any zero seed.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  when high, loads seed_in into the LFSR this cycle.
- seed_in  in  16  seed value; zero is mapped to SEED_DEFAULT.
- entropy  in  1  XORed into the LFSR feedback bit every cycle (e.g. sampled button noise).
- start  in  1  request a new deal; honoured only in IDLE.
- busy  out  1  high while a deal is in progress.
- done  out  1  one-cycle pulse when roles is updated.
- roles  out  2*N_PLAYERS  packed role codes; player 0 in the top two bits. Codes: 00 villager, 01 wolf, 10 doctor; 11 never driven.
- wolf_mask  out  N_PLAYERS  bit i high means player i is a wolf.
- doctor_mask  out  N_PLAYERS  bit i high means player i is a doctor.
- lfsr_q  out  16  current LFSR state, for debug and verification.

Behaviour:
- Reset, asynchronous:
  - state = IDLE; lfsr_q = SEED_DEFAULT.
  - roles, wolf_mask, doctor_mask, internal work vector and counters all cleared to 0.
  - busy = 0, done = 0.
- LFSR update, every cycle, in every state:
  - fb = lfsr_q[0] ^ entropy.
  - next = lfsr_q >> 1; if fb, next ^= LFSR_TAPS.
  - seed_load has priority: lfsr_q = (seed_in == 0) ? SEED_DEFAULT : seed_in, with no step that cycle.
  - seed_load is legal in any state; an ongoing deal simply continues on the new stream.
  - If the LFSR ever reaches 0 (possible only via entropy), it is forced to SEED_DEFAULT on the next cycle.
- Candidate index: cand = lfsr_q[IDX_W-1:0], where IDX_W = clog2(N_PLAYERS).
- FSM states:
  - IDLE: busy = 0. On start go to CLEAR; otherwise stay.
  - CLEAR: one cycle. Clear the work vector and set the pick counter to 0. Go to PICK_W.
  - PICK_W: accept cand if cand < N_PLAYERS and slot cand is villager; write 01 there and increment the counter. Otherwise reject and retry next cycle. After N_WOLVES accepts: go to PICK_D if N_DOCTORS > 0, else COMMIT.
  - PICK_D: same accept/reject rule, writing 10. After N_DOCTORS accepts, go to COMMIT.
  - COMMIT: copy the work vector to roles and update both masks; pulse done for this cycle; go to IDLE.
- busy is high in CLEAR, PICK_W, PICK_D and COMMIT.
- roles and the masks change only in COMMIT, so they stay stable for the whole deal.
- Latency: start sampled at edge t gives done at cycle t+2+N_WOLVES+N_DOCTORS at minimum; each rejection adds one cycle. Latency is unbounded in principle but finite for any non-zero LFSR state.
- Simultaneous events:
  - start while busy: ignored, not queued.
  - start in the same cycle as COMMIT: ignored.
  - start together with seed_load in IDLE: both take effect; CLEAR runs while the LFSR holds the new seed.
- Reset mid-deal: immediate return to IDLE with roles cleared to all villagers; no done pulse.
- Invariant after every COMMIT: popcount(wolf_mask) = N_WOLVES, popcount(doctor_mask) = N_DOCTORS, and wolf_mask & doctor_mask = 0.

Decomposition:
- Package werewolf_pkg holds:
  - role codes ROLE_VILLAGER = 2'b00, ROLE_WOLF = 2'b01, ROLE_DOCTOR = 2'b10;
  - the FSM state enum;
  - the default constants LFSR_TAPS_16 and SEED_DEFAULT_16.
- One sub-module, galois_lfsr16, contains the step, load and zero-recovery logic, with ports clock, reset_n, load, load_value, entropy, q.
- The dealing FSM and work vector stay in role_dealer.

Test Plan:
- Reset with defaults -> roles = 10'b0, busy = 0, done = 0, lfsr_q = 16'hACE1.
- Reset release, entropy = 0, one clock -> lfsr_q = 16'hE270.
- seed_load = 1 with seed_in = 0 -> lfsr_q = 16'hACE1 the next cycle and no step.
- Defaults, entropy = 0, start pulse, checked against a C/Python reference model of the same LFSR and accept rule:
  - roles matches the model's 10-bit vector;
  - exactly one 01 and one 10 code present;
  - done is one cycle wide;
  - busy = 1 for (done cycle − start cycle) cycles.
- Parameters N_PLAYERS = 8, N_WOLVES = 2, N_DOCTORS = 2, 1000 deals with random seeds and entropy:
  - every COMMIT satisfies the popcount and disjointness invariants;
  - no code 11 ever appears;
  - no index ≥ 8 is ever written.
- Mid-deal events:
  - start asserted while busy -> no second deal and exactly one done pulse.
  - reset_n low in PICK_W -> busy drops asynchronously, roles = 0, and no done pulse follows.

Source files
------------

// File: rtl/werewolf_pkg.sv
// Shared definitions for the werewolf game logic.
//   - role codes as stored in the packed role vectors
//   - dealing FSM state type
//   - default LFSR feedback mask and reset seed
package werewolf_pkg;

  localparam logic [1:0] ROLE_VILLAGER = 2'b00;
  localparam logic [1:0] ROLE_WOLF     = 2'b01;
  localparam logic [1:0] ROLE_DOCTOR   = 2'b10;

  localparam logic [15:0] LFSR_TAPS_16    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT_16 = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PICK_W,
    ST_PICK_D,
    ST_COMMIT
  } deal_state_t;

endpackage

// File: rtl/galois_lfsr16.sv
// 16-bit Galois LFSR with seed load, entropy injection and zero recovery.
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset, q returns to SEED
//   load       in   load load_value this cycle instead of stepping
//   load_value in   16-bit seed; zero is replaced by SEED
//   entropy    in   XORed into the feedback bit every step
//   q          out  current LFSR state
module galois_lfsr16
  import werewolf_pkg::*;
#(
  parameter logic [15:0] TAPS = LFSR_TAPS_16,
  parameter logic [15:0] SEED = SEED_DEFAULT_16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        entropy,
  output logic [15:0] q
);

  logic        fb;
  logic [15:0] stepped;
  logic [15:0] q_next;

  always_comb begin
    fb      = q[0] ^ entropy;
    stepped = q >> 1;
    if (fb) begin
      stepped = stepped ^ TAPS;
    end

    // Load wins over everything; a zero state (reachable only through
    // entropy) is replaced by the default seed instead of being stepped.
    if (load) begin
      q_next = (load_value == '0) ? SEED : load_value;
    end else if (q == '0) begin
      q_next = SEED;
    end else begin
      q_next = stepped;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/role_dealer.sv
// Deals a random role assignment to N_PLAYERS players.
// A start pulse in IDLE clears a work vector, then wolves and doctors are
// placed one per accepted LFSR candidate; rejected candidates (out of range
// or slot already taken) are retried on the next cycle. The finished vector
// is copied to roles/masks in one go, so outputs are stable during a deal.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   seed_load, seed_in    reseed the LFSR (zero maps to SEED_DEFAULT)
//   entropy               noise bit mixed into the LFSR feedback
//   start                 request a new deal (honoured only in IDLE)
//   busy                  deal in progress
//   done                  one-cycle pulse, coincident with roles update
//   roles                 2 bits per player, player 0 in the top bits
//   wolf_mask, doctor_mask  per-player role flags, bit i = player i
//   lfsr_q                current LFSR state
module role_dealer
  import werewolf_pkg::*;
#(
  parameter int unsigned N_PLAYERS    = 5,
  parameter int unsigned N_WOLVES     = 1,
  parameter int unsigned N_DOCTORS    = 1,
  parameter logic [15:0] LFSR_TAPS    = LFSR_TAPS_16,
  parameter logic [15:0] SEED_DEFAULT = SEED_DEFAULT_16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     seed_load,
  input  logic [15:0]              seed_in,
  input  logic                     entropy,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [2*N_PLAYERS-1:0]   roles,
  output logic [N_PLAYERS-1:0]     wolf_mask,
  output logic [N_PLAYERS-1:0]     doctor_mask,
  output logic [15:0]              lfsr_q
);

  localparam int unsigned IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int unsigned CNT_W = 5;

  if (N_PLAYERS < 2 || N_PLAYERS > 16 || N_WOLVES < 1 ||
      N_WOLVES + N_DOCTORS > N_PLAYERS) begin : g_bad_params
    $error("role_dealer: illegal N_PLAYERS/N_WOLVES/N_DOCTORS combination");
  end

  galois_lfsr16 #(
    .TAPS (LFSR_TAPS),
    .SEED (SEED_DEFAULT)
  ) u_lfsr (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (seed_load),
    .load_value (seed_in),
    .entropy    (entropy),
    .q          (lfsr_q)
  );

  deal_state_t            state, state_next;
  logic [2*N_PLAYERS-1:0] work, work_next;
  logic [2*N_PLAYERS-1:0] roles_next;
  logic [N_PLAYERS-1:0]   wolf_next, doctor_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   done_next;
  logic [IDX_W-1:0]       cand;
  logic                   cand_free;
  logic                   accept;
  logic [1:0]             pick_code;

  assign cand = lfsr_q[IDX_W-1:0];
  assign busy = (state != ST_IDLE);

  // A candidate outside 0..N_PLAYERS-1 matches no slot, so the range
  // check falls out of the slot search.
  always_comb begin
    cand_free = 1'b0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (cand == IDX_W'(i) && work[2*(N_PLAYERS-1-i) +: 2] == ROLE_VILLAGER) begin
        cand_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    work_next   = work;
    cnt_next    = cnt;
    roles_next  = roles;
    wolf_next   = wolf_mask;
    doctor_next = doctor_mask;
    done_next   = 1'b0;
    accept      = 1'b0;
    pick_code   = ROLE_VILLAGER;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        work_next  = '0;
        cnt_next   = '0;
        state_next = ST_PICK_W;
      end
      ST_PICK_W: begin
        if (cand_free) begin
          accept    = 1'b1;
          pick_code = ROLE_WOLF;
          cnt_next  = cnt + 1'b1;
          if (cnt == CNT_W'(N_WOLVES - 1)) begin
            cnt_next   = '0;
            state_next = (N_DOCTORS > 0) ? ST_PICK_D : ST_COMMIT;
          end
        end
      end
      ST_PICK_D: begin
        if (cand_free) begin
          accept    = 1'b1;
          pick_code = ROLE_DOCTOR;
          cnt_next  = cnt + 1'b1;
          if (cnt == CNT_W'(N_DOCTORS - 1)) begin
            cnt_next   = '0;
            state_next = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        roles_next = work;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
          wolf_next[i]   = (work[2*(N_PLAYERS-1-i) +: 2] == ROLE_WOLF);
          doctor_next[i] = (work[2*(N_PLAYERS-1-i) +: 2] == ROLE_DOCTOR);
        end
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (accept) begin
      for (int unsigned i = 0; i < N_PLAYERS; i++) begin
        if (cand == IDX_W'(i)) begin
          work_next[2*(N_PLAYERS-1-i) +: 2] = pick_code;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      work        <= '0;
      cnt         <= '0;
      roles       <= '0;
      wolf_mask   <= '0;
      doctor_mask <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      work        <= work_next;
      cnt         <= cnt_next;
      roles       <= roles_next;
      wolf_mask   <= wolf_next;
      doctor_mask <= doctor_next;
      done        <= done_next;
    end
  end

endmodule

// File: tb/tb_role_dealer.sv
// Scoreboard bench for role_dealer: a default 5-player instance and an
// 8-player/2-wolf/2-doctor instance share the same stimulus.
module tb_role_dealer;
  import werewolf_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        entropy;
  logic        start;

  logic        busy5, done5;
  logic [9:0]  roles5;
  logic [4:0]  wm5, dm5;
  logic [15:0] lfsr5;

  logic        busy8, done8;
  logic [15:0] roles8;
  logic [7:0]  wm8, dm8;
  logic [15:0] lfsr8;

  role_dealer dut5 (
    .clock(clock), .reset_n(reset_n), .seed_load(seed_load), .seed_in(seed_in),
    .entropy(entropy), .start(start), .busy(busy5), .done(done5), .roles(roles5),
    .wolf_mask(wm5), .doctor_mask(dm5), .lfsr_q(lfsr5)
  );

  role_dealer #(.N_PLAYERS(8), .N_WOLVES(2), .N_DOCTORS(2)) dut8 (
    .clock(clock), .reset_n(reset_n), .seed_load(seed_load), .seed_in(seed_in),
    .entropy(entropy), .start(start), .busy(busy8), .done(done8), .roles(roles8),
    .wolf_mask(wm8), .doctor_mask(dm8), .lfsr_q(lfsr8)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          done_cyc;
    int          lat;
    logic [31:0] roles;
    logic [15:0] wm;
    logic [15:0] dm;
  } exp_t;

  exp_t q5[$];
  exp_t q8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mstep(input logic [15:0] l, input logic e);
    logic [15:0] n;
    if (l == 16'h0) return SEED_DEFAULT_16;
    n = l >> 1;
    if (l[0] ^ e) n = n ^ LFSR_TAPS_16;
    return n;
  endfunction

  // Reference deal: walk the LFSR sequence the dealer will see, one
  // candidate per cycle starting the cycle after CLEAR.
  function automatic void model_deal(input int np, input int nw, input int nd,
                                     input logic [15:0] seed, input logic [255:0] ent,
                                     output exp_t r, output bit ok);
    int slot[16];
    int picks = 0;
    int k = 0;
    int span = 1;
    int cand;
    logic [15:0] l;
    while (span < np) span = span * 2;
    for (int i = 0; i < 16; i++) slot[i] = 0;
    l = (seed == 16'h0) ? SEED_DEFAULT_16 : seed;
    while (picks < nw + nd && k < 200) begin
      l = mstep(l, ent[k]);
      k++;
      cand = int'(l) % span;
      if (cand < np && slot[cand] == 0) begin
        slot[cand] = (picks < nw) ? 1 : 2;
        picks++;
      end
    end
    ok = (picks == nw + nd);
    r.done_cyc = 0;
    r.lat = k + 2;
    r.roles = '0;
    r.wm = '0;
    r.dm = '0;
    for (int i = 0; i < np; i++) begin
      r.roles[2*(np-1-i) +: 2] = 2'(slot[i]);
      r.wm[i] = (slot[i] == 1);
      r.dm[i] = (slot[i] == 2);
    end
  endfunction

  // Cycle-level LFSR model
  logic [15:0] model_l;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_l <= SEED_DEFAULT_16;
    else if (seed_load) model_l <= (seed_in == 16'h0) ? SEED_DEFAULT_16 : seed_in;
    else model_l <= mstep(model_l, entropy);
  end

  always @(posedge clock) cyc <= cyc + 1;

  int busy_cnt[2];
  bit prev_done[2];

  task automatic mon(input int dn, input int np, input int nw, input int nd, input logic dv,
                     input logic bv, input logic [31:0] rv, input logic [15:0] wv,
                     input logic [15:0] dmv);
    exp_t e;
    int bad;
    int qs;
    if (bv) busy_cnt[dn]++;
    if (dv) begin
      qs = (dn == 0) ? q5.size() : q8.size();
      check($sformatf("dut%0d_done_one_cycle", np), 64'(prev_done[dn]), 64'd0);
      check($sformatf("dut%0d_done_expected", np), 64'(qs != 0), 64'd1);
      if (qs != 0) begin
        if (dn == 0) e = q5.pop_front();
        else e = q8.pop_front();
        check($sformatf("dut%0d_roles", np), 64'(rv), 64'(e.roles));
        check($sformatf("dut%0d_wolf_mask", np), 64'(wv), 64'(e.wm));
        check($sformatf("dut%0d_doctor_mask", np), 64'(dmv), 64'(e.dm));
        check($sformatf("dut%0d_done_cycle", np), 64'(cyc), 64'(e.done_cyc));
        check($sformatf("dut%0d_busy_cycles", np), 64'(busy_cnt[dn]), 64'(e.lat));
      end
      check($sformatf("dut%0d_wolf_count", np), 64'($countones(wv)), 64'(nw));
      check($sformatf("dut%0d_doctor_count", np), 64'($countones(dmv)), 64'(nd));
      check($sformatf("dut%0d_disjoint", np), 64'(wv & dmv), 64'd0);
      bad = 0;
      for (int i = 0; i < np; i++) if (rv[2*i +: 2] == 2'b11) bad++;
      check($sformatf("dut%0d_no_code11", np), 64'(bad), 64'd0);
      busy_cnt[dn] = 0;
    end
    prev_done[dn] = dv;
  endtask

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt[0] = 0; busy_cnt[1] = 0;
      prev_done[0] = 1'b0; prev_done[1] = 1'b0;
    end else begin
      check("lfsr5_track", 64'(lfsr5), 64'(model_l));
      check("lfsr8_track", 64'(lfsr8), 64'(model_l));
      mon(0, 5, 1, 1, done5, busy5, {22'b0, roles5}, {11'b0, wm5}, {11'b0, dm5});
      mon(1, 8, 2, 2, done8, busy8, {16'b0, roles8}, {8'b0, wm8}, {8'b0, dm8});
    end
  end

  // Called at a negedge with both dealers idle.
  task automatic run_deal(input bit zero_ent, input bit noisy_start);
    logic [255:0] ent;
    logic [15:0]  seed;
    exp_t e5, e8;
    bit ok5, ok8;
    int minlat;
    int k;
    do begin
      seed = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
      for (int i = 0; i < 256; i++) ent[i] = zero_ent ? 1'b0 : 1'($urandom_range(0, 1));
      model_deal(5, 1, 1, seed, ent, e5, ok5);
      model_deal(8, 2, 2, seed, ent, e8, ok8);
    end while (!(ok5 && ok8));
    e5.done_cyc = cyc + 1 + e5.lat;
    e8.done_cyc = cyc + 1 + e8.lat;
    q5.push_back(e5);
    q8.push_back(e8);
    minlat = (e5.lat < e8.lat) ? e5.lat : e8.lat;
    seed_load = 1'b1;
    seed_in = seed;
    start = 1'b1;
    entropy = 1'($urandom_range(0, 1));
    @(negedge clock);
    seed_load = 1'b0;
    seed_in = 16'($urandom);
    k = 0;
    while ((q5.size() > 0 || q8.size() > 0) && k < 300) begin
      entropy = ent[k % 256];
      start = noisy_start && (k <= minlat - 1) && ($urandom_range(0, 2) == 0);
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    check("deal_completes", 64'(q5.size() + q8.size()), 64'd0);
    q5.delete();
    q8.delete();
    repeat ($urandom_range(1, 3)) begin
      entropy = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    seed_load = 1'b0;
    seed_in = 16'h0;
    entropy = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_roles5", 64'(roles5), 64'd0);
    check("reset_busy5", 64'(busy5), 64'd0);
    check("reset_done5", 64'(done5), 64'd0);
    check("reset_lfsr5", 64'(lfsr5), 64'hACE1);
    check("reset_roles8", 64'(roles8), 64'd0);
    check("reset_masks8", 64'({wm8, dm8}), 64'd0);

    reset_n = 1'b1;
    @(negedge clock);
    check("lfsr_first_step", 64'(lfsr5), 64'hE270);

    seed_load = 1'b1;
    seed_in = 16'h0;
    @(negedge clock);
    check("zero_seed_maps_default", 64'(lfsr5), 64'hACE1);
    seed_in = 16'h1234;
    @(negedge clock);
    check("seed_load_no_step", 64'(lfsr5), 64'h1234);
    seed_load = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run_deal(1'b1, i[0]);
    for (int i = 0; i < 1000; i++) run_deal(1'b0, ($urandom_range(0, 3) == 0));

    // Reset while picking wolves: busy must fall immediately, no done after.
    seed_load = 1'b1;
    seed_in = 16'($urandom) | 16'h1;
    start = 1'b1;
    @(negedge clock);
    seed_load = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check("busy_before_reset", 64'({busy5, busy8}), 64'h3);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy_drop", 64'({busy5, busy8}), 64'd0);
    check("async_roles_clear", 64'({roles5, roles8}), 64'd0);
    check("async_masks_clear", 64'({wm5, dm5, wm8, dm8}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("no_done_after_reset", 64'(q5.size() + q8.size()), 64'd0);

    run_deal(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
